// File: rtl/tm1638_scan_ctrl.sv
// TM1638 frame sequencer: per frame a key scan, mode set, full display data write and
// display control write, issued one byte at a time to a latch/busy byte serializer.
module tm1638_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_DIV    = 500000,
    parameter int STEP_DIV       = 2,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*NUM_DIGITS-1:0] seg_data_i,
    input  logic [NUM_DIGITS-1:0]   led_i,
    input  logic [2:0]              brightness_i,
    input  logic                    disp_on_i,
    input  logic                    update_i,
    input  logic                    tm_busy_i,
    input  logic [7:0]              tm_in_i,
    output logic                    tm_cs_o,
    output logic                    tm_rw_o,
    output logic                    tm_latch_o,
    output logic [7:0]              tm_out_o,
    output logic [7:0]              keys_o,
    output logic [7:0]              key_press_o,
    output logic                    key_event_o,
    output logic                    frame_busy_o
);

    localparam int TICK_W = $clog2(REFRESH_DIV + 1);
    localparam int STEP_W = $clog2(STEP_DIV + 1);
    localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);

    // Frame program: one entry per sequencer step.
    localparam logic [5:0] S_KEY_CS   = 6'd0;
    localparam logic [5:0] S_KEY_CMD  = 6'd1;
    localparam logic [5:0] S_RW_RD    = 6'd2;
    localparam logic [5:0] S_RD0      = 6'd3;
    localparam logic [5:0] S_RD3      = 6'd6;
    localparam logic [5:0] S_KEY_END  = 6'd7;
    localparam logic [5:0] S_RW_WR    = 6'd8;
    localparam logic [5:0] S_MODE_CS  = 6'd9;
    localparam logic [5:0] S_MODE_CMD = 6'd10;
    localparam logic [5:0] S_MODE_END = 6'd11;
    localparam logic [5:0] S_DATA_CS  = 6'd12;
    localparam logic [5:0] S_DATA_CMD = 6'd13;
    localparam logic [5:0] S_DATA0    = 6'd14;
    localparam logic [5:0] S_DATA_END = 6'd30;
    localparam logic [5:0] S_CTRL_CS  = 6'd31;
    localparam logic [5:0] S_CTRL_CMD = 6'd32;
    localparam logic [5:0] S_LAST     = 6'd33;

    typedef enum logic [1:0] {ST_IDLE, ST_STEP, ST_WAIT_HI, ST_WAIT_LO} state_e;
    typedef enum logic [2:0] {ACT_CS_LO, ACT_CS_HI, ACT_RW_RD, ACT_RW_WR, ACT_WRITE, ACT_READ} act_e;

    state_e              state_q, state_d;
    logic [5:0]          step_q, step_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic                pending_q, pending_d;
    logic                cs_q, cs_d, rw_q, rw_d, latch_q, latch_d;
    logic [7:0]          out_q, out_d;
    logic [63:0]         seg_snap_q, seg_snap_d;
    logic [7:0]          led_snap_q, led_snap_d;
    logic [2:0]          bright_snap_q, bright_snap_d;
    logic                disp_snap_q, disp_snap_d;
    logic [7:0]          raw_q, raw_d, prev_raw_q, prev_raw_d;
    logic [STAB_W-1:0]   stab_q, stab_d, stab_next;
    logic [7:0]          keys_q, keys_d, press_q, press_d;
    logic                event_q, event_d;

    logic [63:0] seg_pad;
    logic [7:0]  led_pad;
    logic        tick_fire, tick, step_en;
    act_e        act;
    logic [7:0]  act_byte, data_byte;
    logic [3:0]  data_off;
    logic [1:0]  rd_k;
    logic        unused_tm_in;

    assign unused_tm_in = ^{tm_in_i[7:5], tm_in_i[3:1]};

    assign tick_fire = (tick_q == TICK_W'(REFRESH_DIV - 1));
    assign tick      = tick_fire | update_i;
    assign step_en   = (step_cnt_q == STEP_W'(STEP_DIV - 1));
    assign data_off  = 4'(step_q - S_DATA0);
    assign rd_k      = 2'(step_q - S_RD0);

    // Grids beyond NUM_DIGITS read back as zero from the padded images.
    always_comb begin
        seg_pad = '0;
        led_pad = '0;
        seg_pad[8*NUM_DIGITS-1:0] = seg_data_i;
        led_pad[NUM_DIGITS-1:0]   = led_i;
    end

    always_comb begin
        data_byte = data_off[0] ? {7'b0, led_snap_q[data_off[3:1]]}
                                : seg_snap_q[8*data_off[3:1] +: 8];
        act      = ACT_WRITE;
        act_byte = data_byte;
        case (step_q) inside
            S_KEY_CS, S_MODE_CS, S_DATA_CS, S_CTRL_CS:    act = ACT_CS_LO;
            S_KEY_END, S_MODE_END, S_DATA_END, S_LAST:    act = ACT_CS_HI;
            S_RW_RD:                                       act = ACT_RW_RD;
            S_RW_WR:                                       act = ACT_RW_WR;
            [S_RD0:S_RD3]:                                 act = ACT_READ;
            S_KEY_CMD:  act_byte = 8'h42;
            S_MODE_CMD: act_byte = 8'h40;
            S_DATA_CMD: act_byte = 8'hC0;
            S_CTRL_CMD: act_byte = {4'b1000, disp_snap_q, bright_snap_q};
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        step_d        = step_q;
        tick_d        = tick_fire ? '0 : tick_q + TICK_W'(1);
        step_cnt_d    = step_en ? '0 : step_cnt_q + STEP_W'(1);
        pending_d     = pending_q;
        cs_d          = cs_q;
        rw_d          = rw_q;
        latch_d       = 1'b0;
        out_d         = out_q;
        seg_snap_d    = seg_snap_q;
        led_snap_d    = led_snap_q;
        bright_snap_d = bright_snap_q;
        disp_snap_d   = disp_snap_q;
        raw_d         = raw_q;
        prev_raw_d    = prev_raw_q;
        stab_d        = stab_q;
        keys_d        = keys_q;
        press_d       = press_q;
        event_d       = 1'b0;

        if (raw_q != prev_raw_q)                         stab_next = STAB_W'(1);
        else if (stab_q == STAB_W'(DEBOUNCE_SCANS))      stab_next = stab_q;
        else                                             stab_next = stab_q + STAB_W'(1);

        if (state_q == ST_IDLE) begin
            if (tick || pending_q) begin
                state_d       = ST_STEP;
                step_d        = '0;
                pending_d     = 1'b0;
                seg_snap_d    = seg_pad;
                led_snap_d    = led_pad;
                bright_snap_d = brightness_i;
                disp_snap_d   = disp_on_i;
            end
        end else if (tick) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            ST_STEP: begin
                if (step_en && !tm_busy_i) begin
                    step_d = step_q + 6'd1;
                    unique case (act)
                        ACT_CS_LO: cs_d = 1'b0;
                        ACT_CS_HI: begin
                            cs_d = 1'b1;
                            if (step_q == S_LAST) state_d = ST_IDLE;
                        end
                        ACT_RW_RD: rw_d = 1'b0;
                        ACT_RW_WR: begin
                            rw_d       = 1'b1;
                            prev_raw_d = raw_q;
                            stab_d     = stab_next;
                            if (stab_next == STAB_W'(DEBOUNCE_SCANS) && raw_q != keys_q) begin
                                keys_d  = raw_q;
                                press_d = raw_q & ~keys_q;
                                event_d = 1'b1;
                            end
                        end
                        ACT_WRITE: begin
                            out_d   = act_byte;
                            latch_d = 1'b1;
                            step_d  = step_q;
                            state_d = ST_WAIT_HI;
                        end
                        default: begin
                            latch_d = 1'b1;
                            step_d  = step_q;
                            state_d = ST_WAIT_HI;
                        end
                    endcase
                end
            end
            ST_WAIT_HI: if (tm_busy_i) state_d = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (!tm_busy_i) begin
                    if (act == ACT_READ) begin
                        raw_d[{1'b0, rd_k}] = tm_in_i[0];
                        raw_d[{1'b1, rd_k}] = tm_in_i[4];
                    end
                    step_d  = step_q + 6'd1;
                    state_d = ST_STEP;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            step_q        <= '0;
            tick_q        <= '0;
            step_cnt_q    <= '0;
            pending_q     <= 1'b0;
            cs_q          <= 1'b1;
            rw_q          <= 1'b1;
            latch_q       <= 1'b0;
            out_q         <= 8'h00;
            seg_snap_q    <= '0;
            led_snap_q    <= '0;
            bright_snap_q <= '0;
            disp_snap_q   <= 1'b0;
            raw_q         <= '0;
            prev_raw_q    <= '0;
            stab_q        <= '0;
            keys_q        <= '0;
            press_q       <= '0;
            event_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            tick_q        <= tick_d;
            step_cnt_q    <= step_cnt_d;
            pending_q     <= pending_d;
            cs_q          <= cs_d;
            rw_q          <= rw_d;
            latch_q       <= latch_d;
            out_q         <= out_d;
            seg_snap_q    <= seg_snap_d;
            led_snap_q    <= led_snap_d;
            bright_snap_q <= bright_snap_d;
            disp_snap_q   <= disp_snap_d;
            raw_q         <= raw_d;
            prev_raw_q    <= prev_raw_d;
            stab_q        <= stab_d;
            keys_q        <= keys_d;
            press_q       <= press_d;
            event_q       <= event_d;
        end
    end

    assign tm_cs_o      = cs_q;
    assign tm_rw_o      = rw_q;
    assign tm_latch_o   = latch_q;
    assign tm_out_o     = out_q;
    assign keys_o       = keys_q;
    assign key_press_o  = press_q;
    assign key_event_o  = event_q;
    assign frame_busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tm1638_scan_ctrl.sv
// Bench for tm1638_scan_ctrl: behavioural serializer, bus monitor and a history-based
// key model; directed frame sequences with randomized images and key patterns.
module tb_tm1638_scan_ctrl;

    localparam int ND     = 6;
    localparam int RDIV   = 20000;
    localparam int SDIV   = 2;
    localparam int DEB    = 3;
    localparam int NBYTES = 20;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [8*ND-1:0] seg_img = '0;
    logic [ND-1:0]   led_img = '0;
    logic [2:0]      bright = '0;
    logic            disp_on = 1'b0;
    logic            update = 1'b0;
    logic            tm_busy = 1'b0;
    logic [7:0]      tm_in = '0;
    logic            tm_cs, tm_rw, tm_latch, key_event, frame_busy;
    logic [7:0]      tm_out, keys, key_press;

    tm1638_scan_ctrl #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RDIV), .STEP_DIV(SDIV), .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seg_data_i(seg_img), .led_i(led_img),
        .brightness_i(bright), .disp_on_i(disp_on), .update_i(update),
        .tm_busy_i(tm_busy), .tm_in_i(tm_in), .tm_cs_o(tm_cs), .tm_rw_o(tm_rw),
        .tm_latch_o(tm_latch), .tm_out_o(tm_out), .keys_o(keys), .key_press_o(key_press),
        .key_event_o(key_event), .frame_busy_o(frame_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] wr_log[$];
    int         win_lat[$];
    logic [7:0] rd_vals[4];
    int         rd_cnt, cs_falls, lat_outside, frame_rises, ev_pulses;
    logic [7:0] ev_press;
    int         busy_cnt, busy_len;
    bit         pend_busy, prev_cs = 1'b1, prev_fb = 1'b0;

    // Serializer: busy rises the cycle after a latch and stays high 1..4 cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            tm_busy = 1'b0; busy_cnt = 0; pend_busy = 1'b0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tm_busy = 1'b0;
            end
            if (pend_busy) begin
                tm_busy = 1'b1; busy_cnt = busy_len; pend_busy = 1'b0;
            end
            if (tm_latch) begin
                pend_busy = 1'b1;
                busy_len  = $urandom_range(1, 4);
                if (tm_rw) wr_log.push_back(tm_out);
                else begin
                    tm_in = rd_vals[rd_cnt % 4];
                    rd_cnt++;
                end
            end
        end
        if (prev_cs && !tm_cs) begin
            cs_falls++;
            win_lat.push_back(0);
        end
        if (tm_latch) begin
            if (tm_cs || win_lat.size() == 0) lat_outside++;
            else win_lat[win_lat.size()-1] = win_lat[win_lat.size()-1] + 1;
        end
        if (frame_busy && !prev_fb) frame_rises++;
        if (key_event) begin
            ev_pulses++;
            ev_press = key_press;
        end
        prev_cs = tm_cs;
        prev_fb = frame_busy;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Key model: accept a raw scan once the last DEB scans since reset are identical.
    logic [7:0] m_keys;
    logic [7:0] hist[$];
    logic [7:0] exp_b[NBYTES];

    task automatic model_reset();
        hist.delete();
        m_keys = 8'h00;
    endtask

    task automatic model_scan(input logic [7:0] raw, output bit ev, output logic [7:0] press);
        bit stable;
        hist.push_back(raw);
        ev = 1'b0; press = 8'h00; stable = 1'b1;
        if (hist.size() >= DEB) begin
            for (int i = 1; i <= DEB; i++) if (hist[hist.size()-i] != raw) stable = 1'b0;
            if (stable && raw != m_keys) begin
                ev = 1'b1;
                press = raw & ~m_keys;
                m_keys = raw;
            end
        end
    endtask

    task automatic expect_bytes();
        logic [63:0] s;
        logic [7:0]  l;
        s = 64'(seg_img);
        l = 8'(led_img);
        exp_b[0] = 8'h42;
        exp_b[1] = 8'h40;
        exp_b[2] = 8'hC0;
        for (int g = 0; g < 8; g++) begin
            exp_b[3+2*g] = (g < ND) ? s[8*g +: 8] : 8'h00;
            exp_b[4+2*g] = (g < ND) ? {7'b0, l[g]} : 8'h00;
        end
        exp_b[19] = 8'h80 | {4'b0, disp_on, 3'b0} | {5'b0, bright};
    endtask

    task automatic clear_logs();
        wr_log.delete(); win_lat.delete();
        rd_cnt = 0; cs_falls = 0; lat_outside = 0; frame_rises = 0; ev_pulses = 0; ev_press = 8'h00;
    endtask

    task automatic prep(input logic [7:0] raw);
        logic [7:0] v;
        for (int k = 0; k < 4; k++) begin
            v = 8'($urandom);
            v[0] = raw[k];
            v[4] = raw[k+4];
            rd_vals[k] = v;
        end
        expect_bytes();
        clear_logs();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    task automatic randomize_image();
        seg_img = 48'({$urandom(), $urandom()});
        led_img = 6'($urandom());
        bright  = 3'($urandom());
        disp_on = 1'($urandom());
    endtask

    task automatic wait_done(input int n, input string tag);
        int c = 0;
        while (!(frame_rises >= n && !frame_busy) && c < 6000) begin
            step();
            c++;
        end
        check({tag, " frame_timeout"}, 64'(c < 6000), 64'd1);
    endtask

    task automatic wait_writes(input int n, input string tag);
        int c = 0;
        while (wr_log.size() < n && c < 3000) begin
            step();
            c++;
        end
        check({tag, " write_timeout"}, 64'(c < 3000), 64'd1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] raw);
        bit          ev;
        logic [7:0]  press;
        logic [31:0] w;
        model_scan(raw, ev, press);
        check({tag, " writes"}, 64'(wr_log.size()), 64'(NBYTES));
        for (int i = 0; i < NBYTES && i < wr_log.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 64'(wr_log[i]), 64'(exp_b[i]));
        w = '0;
        for (int i = 0; i < 4 && i < win_lat.size(); i++) w[8*i +: 8] = 8'(win_lat[i]);
        check({tag, " reads"}, 64'(rd_cnt), 64'd4);
        check({tag, " cs_windows"}, 64'(cs_falls), 64'd4);
        check({tag, " latches_per_window"}, 64'(w), 64'h01_11_01_05);
        check({tag, " latch_outside_cs"}, 64'(lat_outside), 64'd0);
        check({tag, " cs_idle"}, 64'(tm_cs), 64'd1);
        check({tag, " keys"}, 64'(keys), 64'(m_keys));
        check({tag, " key_event_cycles"}, 64'(ev_pulses), 64'(ev));
        if (ev) check({tag, " key_press"}, 64'(ev_press), 64'(press));
    endtask

    task automatic run_frame(input logic [7:0] raw, input string tag);
        prep(raw);
        pulse_update();
        wait_done(1, tag);
        check_frame(tag, raw);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        model_reset();
        clear_logs();
        step();
    endtask

    initial begin
        int         n;
        int         reps;
        logic [7:0] p;
        logic [7:0] kseq[6];

        // Reset state and free-running tick period.
        model_reset();
        randomize_image();
        repeat (3) step();
        check("rst tm_cs", 64'(tm_cs), 64'd1);
        check("rst tm_rw", 64'(tm_rw), 64'd1);
        check("rst tm_latch", 64'(tm_latch), 64'd0);
        check("rst tm_out", 64'(tm_out), 64'h00);
        check("rst keys", 64'(keys), 64'h00);
        check("rst key_press", 64'(key_press), 64'h00);
        check("rst key_event", 64'(key_event), 64'd0);
        check("rst frame_busy", 64'(frame_busy), 64'd0);
        prep(8'h00);
        rst_n = 1'b1;
        n = 0;
        while (!frame_busy && n < RDIV + 20) begin
            step();
            n++;
        end
        check("tick_period", 64'(n), 64'(RDIV));
        wait_done(1, "tick_frame");
        check_frame("tick_frame", 8'h00);

        // Debounce: three identical scans accept, a glitch in the middle does not.
        do_reset();
        kseq = '{8'h11, 8'h11, 8'h11, 8'h33, 8'h00, 8'h33};
        for (int i = 0; i < 6; i++) begin
            randomize_image();
            run_frame(kseq[i], $sformatf("deb%0d", i));
        end
        check("deb keys_after_glitch", 64'(keys), 64'h11);

        // Random images and key patterns held for 1..4 scans.
        for (int i = 0; i < 10; i++) begin
            p = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            reps = $urandom_range(1, 4);
            for (int r = 0; r < reps; r++) begin
                randomize_image();
                run_frame(p, $sformatf("rnd%0d_%0d", i, r));
            end
        end

        // Two updates during a frame merge into exactly one extra frame.
        do_reset();
        randomize_image();
        prep(8'h00);
        pulse_update();
        repeat (40) step();
        pulse_update();
        repeat (5) step();
        pulse_update();
        wait_done(2, "pend");
        repeat (600) step();
        check("pend frames", 64'(frame_rises), 64'd2);
        check("pend writes", 64'(wr_log.size()), 64'(2 * NBYTES));
        check("pend reads", 64'(rd_cnt), 64'd8);
        for (int i = 0; i < 2 * NBYTES && i < wr_log.size(); i++)
            check($sformatf("pend byte%0d", i), 64'(wr_log[i]), 64'(exp_b[i % NBYTES]));

        // Inputs changed mid-DATA only reach the following frame.
        do_reset();
        randomize_image();
        prep(8'h00);
        pulse_update();
        wait_writes(5, "snap");
        seg_img = ~seg_img;
        led_img = ~led_img;
        bright  = ~bright;
        disp_on = ~disp_on;
        wait_done(1, "snap_old");
        check_frame("snap_old", 8'h00);
        run_frame(8'h00, "snap_new");

        // Reset in the middle of DATA with keys held.
        do_reset();
        for (int i = 0; i < 3; i++) run_frame(8'h81, $sformatf("pre_rst%0d", i));
        check("pre_rst keys", 64'(keys), 64'h81);
        prep(8'h81);
        pulse_update();
        wait_writes(6, "mid_rst");
        rst_n = 1'b0;
        step();
        check("mid_rst tm_cs", 64'(tm_cs), 64'd1);
        check("mid_rst tm_latch", 64'(tm_latch), 64'd0);
        check("mid_rst keys", 64'(keys), 64'h00);
        check("mid_rst frame_busy", 64'(frame_busy), 64'd0);
        check("mid_rst tm_out", 64'(tm_out), 64'h00);
        rst_n = 1'b1;
        model_reset();
        clear_logs();
        repeat (400) step();
        check("post_rst latches", 64'(wr_log.size() + rd_cnt + lat_outside), 64'd0);
        check("post_rst cs_windows", 64'(cs_falls), 64'd0);
        check("post_rst frame_busy", 64'(frame_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
